// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encodings and default counter width.
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEAS  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 18;

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchronizer for an asynchronous input with rise/fall strobes and the synchronized level.
module sync_edge_detect (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic level
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
  assign level = s2;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous input in clk cycles; flags a stalled input.
// Optional CLKMETER_DUTY_EN adds high_time (cycles high within the last period).
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | after reset, waiting for the anchor edge
// ST_MEAS  | counting cycles since the last rise
// ST_STALL | counter saturated with no rise seen
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             slow_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             period_ok,
  output logic             stalled
`ifdef CLKMETER_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rise, fall, level;

  sync_edge_detect u_sync (
    .clk   (clk),
    .clr   (clr),
    .d     (slow_in),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

`ifdef CLKMETER_DUTY_EN
  logic [CNT_W-1:0] hi_lat;
  // fell marks that hi_lat belongs to the current period; otherwise the input stayed high throughout
  logic             fell;
  logic             unused_sync;
  assign unused_sync = level;
`else
  logic unused_sync;
  assign unused_sync = fall ^ level;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      period_ok  <= 1'b0;
      stalled    <= 1'b0;
`ifdef CLKMETER_DUTY_EN
      hi_lat     <= '0;
      fell       <= 1'b0;
      high_time  <= '0;
`endif
    end else begin
      period_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            cnt   <= CNT_ONE;
            state <= ST_MEAS;
`ifdef CLKMETER_DUTY_EN
            fell  <= 1'b0;
`endif
          end else begin
            cnt <= '0;
          end
        end
        ST_MEAS: begin
          // a rise on the saturation cycle still publishes, so it is checked first
          if (rise) begin
            period     <= cnt;
            period_vld <= 1'b1;
            period_ok  <= 1'b1;
            cnt        <= CNT_ONE;
`ifdef CLKMETER_DUTY_EN
            high_time  <= fell ? hi_lat : cnt;
            fell       <= 1'b0;
`endif
          end else begin
            if (cnt == CNT_MAX) begin
              state     <= ST_STALL;
              stalled   <= 1'b1;
              period_ok <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
`ifdef CLKMETER_DUTY_EN
            if (fall) begin
              hi_lat <= cnt;
              fell   <= 1'b1;
            end
`endif
          end
        end
        ST_STALL: begin
          if (rise) begin
            stalled <= 1'b0;
            cnt     <= CNT_ONE;
            state   <= ST_MEAS;
`ifdef CLKMETER_DUTY_EN
            fell    <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter at CNT_W=8 (saturation 255).
module tb_clock_period_meter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         slow_in = 1'b0;
  logic [W-1:0] period;
  logic         period_vld;
  logic         period_ok;
  logic         stalled;
`ifdef CLKMETER_DUTY_EN
  logic [W-1:0] high_time;
`endif

  clock_period_meter #(.CNT_W(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .slow_in    (slow_in),
    .period     (period),
    .period_vld (period_vld),
    .period_ok  (period_ok),
    .stalled    (stalled)
`ifdef CLKMETER_DUTY_EN
    ,
    .high_time  (high_time)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   n_vld = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int p, input int h, input int n);
    exp_t e;
    e.p = p;
    e.h = h;
    repeat (n) q.push_back(e);
  endtask

  // n rising edges spaced gap cycles apart, each high for hi cycles
  task automatic wave(input int gap, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      slow_in = 1'b1;
      tick(hi);
      slow_in = 1'b0;
      tick(gap - hi);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    tick(2);
  endtask

  // monitor: every period_vld pops one expected measurement
  always @(negedge clk) begin
    if (!clr && period_vld) begin
      exp_t e;
      n_vld++;
      if (q.size() == 0) begin
        chk("unexpected_vld", 32'(period), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("period", 32'(period), e.p);
`ifdef CLKMETER_DUTY_EN
        chk("high_time", 32'(high_time), e.h);
`endif
      end
    end
  end

  initial begin
    logic [17:0] fc;
    int          n0;

    // reset state
    tick(2);
    chk("rst_period", 32'(period), 0);
    chk("rst_vld", 32'(period_vld), 0);
    chk("rst_ok", 32'(period_ok), 0);
    chk("rst_stalled", 32'(stalled), 0);
    clr = 1'b0;

    // free-running counter bit 6: 128-cycle period, high 64
    fc = '0;
    push(128, 64, 5);
    for (int i = 0; i < 768; i++) begin
      slow_in = fc[6];
      tick(1);
      fc = fc + 1'b1;
    end
    tick(5);
    chk("p1_q_empty", q.size(), 0);
    chk("p1_ok", 32'(period_ok), 1);
    chk("p1_period", 32'(period), 128);

    // stall after one measured period, then recovery
    slow_in = 1'b0;
    pulse_clr();
    push(30, 10, 1);
    wave(30, 10, 2);
    tick(227);
    chk("p2_stalled_before", 32'(stalled), 0);
    tick(1);
    chk("p2_stalled", 32'(stalled), 1);
    chk("p2_ok_cleared", 32'(period_ok), 0);
    chk("p2_period_held", 32'(period), 30);
    push(50, 20, 1);
    wave(50, 20, 2);
    tick(5);
    chk("p2_stall_cleared", 32'(stalled), 0);
    chk("p2_ok_restored", 32'(period_ok), 1);
    chk("p2_q_empty", q.size(), 0);

    // minimum period of 2
    pulse_clr();
    n0 = n_vld;
    push(2, 1, 19);
    wave(2, 1, 20);
    tick(5);
    chk("p3_vld_count", n_vld - n0, 19);
    chk("p3_q_empty", q.size(), 0);

    // clr in the middle of a period
    pulse_clr();
    push(60, 30, 2);
    wave(60, 30, 2);
    slow_in = 1'b1;
    tick(20);
    chk("p4_period_before_clr", 32'(period), 60);
    slow_in = 1'b0;
    clr = 1'b1;
    #1;
    chk("p4_clr_period", 32'(period), 0);
    chk("p4_clr_vld", 32'(period_vld), 0);
    chk("p4_clr_ok", 32'(period_ok), 0);
    chk("p4_clr_stalled", 32'(stalled), 0);
`ifdef CLKMETER_DUTY_EN
    chk("p4_clr_high_time", 32'(high_time), 0);
`endif
    tick(2);
    clr = 1'b0;
    tick(2);
    n0 = n_vld;
    push(100, 40, 1);
    wave(100, 40, 2);
    tick(5);
    chk("p4_vld_count", n_vld - n0, 1);
    chk("p4_q_empty", q.size(), 0);

    // slow_in high while clr releases: anchor comes from the release
    slow_in = 1'b1;
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    push(40, 20, 1);
    tick(20);
    slow_in = 1'b0;
    tick(20);
    slow_in = 1'b1;
    tick(10);
    slow_in = 1'b0;
    tick(5);
    chk("p5_q_empty", q.size(), 0);
    chk("p5_period", 32'(period), 40);

    // rise exactly on the saturation cycle
    pulse_clr();
    push(255, 100, 1);
    slow_in = 1'b1;
    tick(100);
    slow_in = 1'b0;
    tick(155);
    slow_in = 1'b1;
    tick(3);
    chk("p6_vld", 32'(period_vld), 1);
    chk("p6_period", 32'(period), 255);
    chk("p6_stalled", 32'(stalled), 0);
    chk("p6_ok", 32'(period_ok), 1);
    tick(1);
    chk("p6_stalled_after", 32'(stalled), 0);
    slow_in = 1'b0;
    tick(300);
    chk("p6_stall_late", 32'(stalled), 1);
    chk("p6_ok_late", 32'(period_ok), 0);
    chk("p6_period_held", 32'(period), 255);
    chk("final_q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
